// File: rtl/batch_cost_accumulator_pkg.sv
// cost_pkg: shared batch-sequencer state encoding and cost datapath constants
package cost_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SAMPLE, LAUNCH, WAIT_CALC, ACCUM, DONE} batch_state_e;
  localparam int COST_WIDTH = 8;
  localparam int LABEL_COUNT = 10;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to 1 after reaching rollover_val
module flex_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : !count_enable ? count_q : (count_q == rollover_val) ? WIDTH'(1) : count_q + 1'b1;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count_q <= '0;
    else count_q <= count_d;
  assign count_out = count_q;
endmodule

// File: rtl/batch_cost_accumulator.sv
// batch_cost_accumulator: sequences samples through the cost calculator and emits the batch mean cost
module batch_cost_accumulator
  import cost_pkg::*;
#(
  parameter int BATCH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         batch_start,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         cost_en,
  input  logic                         calculation_complete,
  input  logic [COST_WIDTH-1:0]        cost_output,
  output logic                         busy,
  output logic [BATCH_LOG2:0]          sample_count,
  output logic [COST_WIDTH+BATCH_LOG2-1:0] batch_sum,
  output logic [COST_WIDTH-1:0]        batch_cost,
  output logic                         batch_done,
  output logic                         timeout_err
);
  localparam int SUM_WIDTH = COST_WIDTH + BATCH_LOG2;
  localparam int CW = BATCH_LOG2 + 1;
  batch_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [COST_WIDTH-1:0] capture_q, capture_d, cost_q, cost_d;
  logic timeout_q, timeout_d, done_q, done_d;
  logic [6:0] wd_count;
  logic wd_expired;
  flex_counter #(.WIDTH(7)) u_watchdog (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_q == LAUNCH),
    .count_enable (state_q == WAIT_CALC),
    .rollover_val (7'(TIMEOUT_CYCLES)),
    .count_out    (wd_count)
  );
  assign wd_expired = wd_count == 7'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    capture_d = capture_q;
    cost_d    = cost_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    if (batch_start) begin
      state_d   = WAIT_SAMPLE;
      count_d   = '0;
      sum_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_SAMPLE: state_d = sample_valid ? LAUNCH : WAIT_SAMPLE;
        LAUNCH:      state_d = WAIT_CALC;
        WAIT_CALC: begin
          if (calculation_complete) begin
            capture_d = cost_output;
            state_d   = ACCUM;
          end else if (wd_expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
        ACCUM: begin
          sum_d   = sum_q + SUM_WIDTH'(capture_q);
          count_d = count_q + 1'b1;
          state_d = (count_d == CW'(2 ** BATCH_LOG2)) ? DONE : WAIT_SAMPLE;
        end
        DONE: begin
          cost_d  = COST_WIDTH'(sum_q >> BATCH_LOG2);
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      capture_q <= '0;
      cost_q    <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      capture_q <= capture_d;
      cost_q    <= cost_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  assign sample_ready = state_q == WAIT_SAMPLE;
  assign cost_en      = state_q == LAUNCH;
  assign busy         = state_q != IDLE;
  assign sample_count = count_q;
  assign batch_sum    = sum_q;
  assign batch_cost   = cost_q;
  assign batch_done   = done_q;
  assign timeout_err  = timeout_q;
endmodule

// File: tb/tb_batch_cost_accumulator.sv
// tb_batch_cost_accumulator: randomized bench with a transaction-level model of batch sums and means
module tb_batch_cost_accumulator;
  localparam int B = 2;
  localparam int N = 1 << B;
  localparam int K_CLR = 0, K_EN = 1, K_ACC = 2, K_DONE = 3, K_TO = 4;
  typedef struct {int at; int kind; int val; int val2;} ev_t;
  logic clk = 0, n_rst = 0, batch_start = 0, sample_valid = 0, calculation_complete = 0;
  logic [7:0] cost_output = 0;
  logic sample_ready, cost_en, busy, batch_done, timeout_err;
  logic [B:0] sample_count;
  logic [7+B:0] batch_sum;
  logic [7:0] batch_cost;
  int compared = 0, failed = 0, cyc = 0;
  bit chk_on = 0;
  ev_t evq[$];
  int m_sum = 0, m_cnt = 0, m_cost = 0, m_to = 0, e_en, e_done;
  int d_sum = 0, d_cnt = 0, en_seen = 0, done_seen = 0;
  batch_cost_accumulator #(.BATCH_LOG2(B), .TIMEOUT_CYCLES(127)) dut (
    .clk(clk), .n_rst(n_rst), .batch_start(batch_start), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .cost_en(cost_en), .calculation_complete(calculation_complete),
    .cost_output(cost_output), .busy(busy), .sample_count(sample_count), .batch_sum(batch_sum),
    .batch_cost(batch_cost), .batch_done(batch_done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cost_en) en_seen++;
    if (batch_done) done_seen++;
    if (chk_on) begin
      e_en = 0;
      e_done = 0;
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i].at == cyc) begin
          case (evq[i].kind)
            K_CLR: begin m_sum = 0; m_cnt = 0; m_to = 0; end
            K_EN: e_en = 1;
            K_ACC: begin m_sum = evq[i].val; m_cnt = evq[i].val2; end
            K_DONE: begin e_done = 1; m_cost = evq[i].val; end
            default: m_to = 1;
          endcase
          evq.delete(i);
        end
      chk("cost_en", int'(cost_en), e_en);
      chk("batch_done", int'(batch_done), e_done);
      chk("batch_sum", int'(batch_sum), m_sum);
      chk("sample_count", int'(sample_count), m_cnt);
      chk("batch_cost", int'(batch_cost), m_cost);
      chk("timeout_err", int'(timeout_err), m_to);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_batch();
    batch_start = 1;
    evq.push_back('{cyc + 1, K_CLR, 0, 0});
    d_sum = 0;
    d_cnt = 0;
    tick();
    batch_start = 0;
  endtask
  task automatic handshake(output int l);
    int n = 0;
    while (!sample_ready && n < 300) begin tick(); n++; end
    if (!sample_ready) chk("ready_wait", 0, 1);
    sample_valid = 1;
    l = cyc + 1;
    evq.push_back('{l, K_EN, 0, 0});
    tick();
    sample_valid = 0;
  endtask
  task automatic calc(input int d, input int cost);
    tick();
    repeat (d) tick();
    calculation_complete = 1;
    cost_output = 8'(cost);
    d_sum += cost;
    d_cnt++;
    evq.push_back('{cyc + 2, K_ACC, d_sum, d_cnt});
    if (d_cnt == N) evq.push_back('{cyc + 3, K_DONE, d_sum >> B, 0});
    tick();
    calculation_complete = 0;
    cost_output = 8'($urandom);
  endtask
  task automatic run_samples(input int c0, input int c1, input int c2, input int c3, input int maxd);
    int costs[4];
    int l;
    costs = '{c0, c1, c2, c3};
    for (int i = 0; i < N; i++) begin
      handshake(l);
      calc($urandom_range(0, maxd), costs[i]);
    end
    repeat (3) tick();
  endtask
  initial begin
    int l, en0, dn0;
    #500000;
    $display("FAIL global_timeout cyc=%0d got=hang exp=finish", cyc);
    $fatal(1, "bench timeout");
  end
  initial begin
    int l, en0, dn0, prev;
    repeat (3) tick();
    chk("rst_ready", int'(sample_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cost_en", int'(cost_en), 0);
    chk("rst_sum", int'(batch_sum), 0);
    chk("rst_cost", int'(batch_cost), 0);
    @(negedge clk);
    n_rst = 1;
    tick();
    chk_on = 1;
    en0 = en_seen;
    dn0 = done_seen;
    start_batch();
    run_samples(10, 20, 30, 40, 30);
    chk("b1_cost_en_pulses", en_seen - en0, 4);
    chk("b1_done_pulses", done_seen - dn0, 1);
    chk("b1_sum", int'(batch_sum), 100);
    chk("b1_cost", int'(batch_cost), 25);
    chk("b1_busy_after", int'(busy), 0);
    start_batch();
    run_samples(255, 255, 255, 255, 10);
    chk("max_sum", int'(batch_sum), 1020);
    chk("max_cost", int'(batch_cost), 255);
    for (int r = 0; r < 4; r++) begin
      start_batch();
      run_samples($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 50);
    end
    start_batch();
    handshake(l);
    calc(3, 77);
    handshake(l);
    evq.push_back('{l + 128, K_TO, 0, 0});
    while (cyc < l + 128) tick();
    chk("to_err", int'(timeout_err), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_count", int'(sample_count), 1);
    chk("to_sum", int'(batch_sum), 77);
    start_batch();
    chk("to_cleared", int'(timeout_err), 0);
    start_batch();
    run_samples(40, 40, 40, 40, 20);
    prev = int'(batch_cost);
    chk("pre_abort_cost", prev, 40);
    start_batch();
    handshake(l);
    calc(2, 7);
    handshake(l);
    calc(4, 9);
    handshake(l);
    repeat (4) tick();
    batch_start = 1;
    calculation_complete = 1;
    cost_output = 8'd100;
    evq.push_back('{cyc + 1, K_CLR, 0, 0});
    d_sum = 0;
    d_cnt = 0;
    tick();
    batch_start = 0;
    calculation_complete = 0;
    chk("abort_sum", int'(batch_sum), 0);
    chk("abort_count", int'(sample_count), 0);
    chk("abort_cost_kept", int'(batch_cost), 40);
    run_samples(5, 5, 5, 5, 15);
    chk("post_abort_cost", int'(batch_cost), 5);
    start_batch();
    calculation_complete = 1;
    cost_output = 8'd200;
    tick();
    calculation_complete = 0;
    repeat (20) tick();
    chk("stray_sum", int'(batch_sum), 0);
    chk("stray_ready", int'(sample_ready), 1);
    handshake(l);
    tick();
    calculation_complete = 1;
    cost_output = 8'd50;
    tick();
    calculation_complete = 0;
    chk_on = 0;
    n_rst = 0;
    #1;
    chk("rstmid_ready", int'(sample_ready), 0);
    chk("rstmid_cost_en", int'(cost_en), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_done", int'(batch_done), 0);
    chk("rstmid_to", int'(timeout_err), 0);
    chk("rstmid_count", int'(sample_count), 0);
    chk("rstmid_sum", int'(batch_sum), 0);
    chk("rstmid_cost", int'(batch_cost), 0);
    evq.delete();
    m_sum = 0; m_cnt = 0; m_cost = 0; m_to = 0;
    @(negedge clk);
    n_rst = 1;
    en0 = en_seen;
    repeat (5) tick();
    chk_on = 1;
    repeat (3) tick();
    chk("post_rst_cost_en", en_seen - en0, 0);
    chk("post_rst_busy", int'(busy), 0);
    start_batch();
    run_samples($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 40);
    chk("pending_events", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/batch_cost_accumulator.md
Name: batch_cost_accumulator

Overview:
- Sequencer and accumulator directly downstream of the per-sample cost calculator.
- Accepts one sample per valid/ready handshake and launches the cost calculator with a one-cycle cost_en pulse.
- Waits for calculation_complete, then adds cost_output into a batch sum.
- After 2^BATCH_LOG2 samples, emits the batch mean cost and a one-cycle batch_done. Includes a watchdog against a hung calculator.

Parameters:
- BATCH_LOG2, 4, log2 of samples per batch (1..8).
- TIMEOUT_CYCLES, 127, maximum cycles in WAIT_CALC before error (must exceed calculator latency, about 52 cycles).
- SUM_WIDTH (localparam), 8+BATCH_LOG2, batch sum width. Cannot overflow: 255*2^B < 2^(8+B).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- batch_start  in  1  begin a new batch; clears sum and count
- sample_valid  in  1  upstream has label and confidences ready for the calculator
- sample_ready  out  1  block can accept a sample
- cost_en  out  1  one-cycle launch pulse to the cost calculator
- calculation_complete  in  1  calculator finished pulse; cost_output is valid in the same cycle
- cost_output  in  8  per-sample cost
- busy  out  1  high in any state except IDLE
- sample_count  out  BATCH_LOG2+1  samples accumulated in the current batch
- batch_sum  out  SUM_WIDTH  running sum
- batch_cost  out  8  mean cost of the last completed batch
- batch_done  out  1  one-cycle pulse when batch_cost updates
- timeout_err  out  1  sticky; cleared by batch_start or reset

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, n_rst).
- Reset values:
  - state = IDLE.
  - All outputs 0: sample_ready, cost_en, busy, batch_done, timeout_err, sample_count, batch_sum, batch_cost.
- IDLE:
  - batch_start=1 → clear batch_sum, sample_count, timeout_err; go to WAIT_SAMPLE.
  - Otherwise stay.
- WAIT_SAMPLE:
  - sample_ready=1.
  - sample_valid & sample_ready → LAUNCH (handshake cycle).
- LAUNCH:
  - cost_en=1 for exactly this cycle.
  - Clear watchdog; go to WAIT_CALC.
  - Upstream holds expected_label and digit_weights stable from the handshake cycle through LAUNCH.
- WAIT_CALC:
  - Watchdog increments each cycle.
  - calculation_complete=1 → register cost_output into a capture register; go to ACCUM.
  - Watchdog reaching TIMEOUT_CYCLES with no complete → set timeout_err; go to IDLE. Sum and count are kept for debug.
- ACCUM:
  - batch_sum += capture (zero-extended); sample_count += 1.
  - If the new count == 2^BATCH_LOG2 → DONE, else → WAIT_SAMPLE.
- DONE:
  - batch_cost <= batch_sum >> BATCH_LOG2 (truncating; always fits in 8 bits).
  - batch_done=1 for this cycle; go to IDLE.
  - batch_cost holds until the next DONE.
- Latency:
  - Handshake to cost_en: 1 cycle.
  - calculation_complete to batch_sum update: 2 cycles.
  - Last complete to batch_done: 3 cycles.
- Boundary conditions:
  - batch_start in any non-IDLE state aborts: clear sum, count, timeout_err; go to WAIT_SAMPLE. batch_cost is unchanged.
  - batch_start takes priority over calculation_complete in the same cycle.
  - calculation_complete outside WAIT_CALC is ignored.
  - sample_valid outside WAIT_SAMPLE is ignored; upstream must hold it.
  - Reset mid-batch returns to reset values immediately (asynchronous).
- State outputs (sample_ready, cost_en, batch_done, busy) are decoded from registered state; no combinational path from inputs to outputs.

Decomposition:
- Package cost_pkg:
  - batch state enum {IDLE, WAIT_SAMPLE, LAUNCH, WAIT_CALC, ACCUM, DONE}.
  - COST_WIDTH=8, LABEL_COUNT=10.
- Sub-module: reuse flex_counter (width 7) as the watchdog, with clear on LAUNCH and count_enable in WAIT_CALC.
- Sample counter and sum stay inline.

Test Plan:
- BATCH_LOG2=2, costs 10,20,30,40 → exactly 4 cost_en pulses, batch_sum=100, batch_cost=25, one batch_done pulse, busy falls the cycle after.
- BATCH_LOG2=2, all costs 255 → batch_sum=1020, batch_cost=255, no wrap.
- Calculator model never completes after the 2nd sample → timeout_err=1 after 127 WAIT_CALC cycles, state IDLE, sample_count=1; next batch_start clears timeout_err.
- batch_start asserted during WAIT_CALC of the 3rd sample → sum and count return to 0; a new 4-sample batch (5,5,5,5) gives batch_cost=5; previous batch_cost is retained until then.
- Stray calculation_complete in WAIT_SAMPLE with cost 200 → batch_sum unchanged; sample_valid held low leaves sample_ready=1 indefinitely.
- Reset asserted mid-ACCUM → all outputs 0 asynchronously; after release, state IDLE and cost_en stays 0 until batch_start.
